jtag_txrx_mem: RTL and testbench
================================

# jtag_txrx_mem

Single-clock buffer memory that sits downstream of the JTAG virtual data register stage in the `tck` domain. It stores words written by the host through `wram_enable`/`waddr`/`wdata` and returns `rdata` for the host's `raddr`. It also runs fill/clear commands issued through the flags register, and exposes write statistics at a reserved read window so the host can verify transfers without a second instruction.

## Interface
- `DR_LENGTH`, 32: data/address/flags width; fixed at 32.
- `ADDR_BITS`, 10: memory depth is 2^ADDR_BITS words; legal range 4..16.

- `tck`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wram_enable`  in  1  one-cycle host write strobe.
- `waddr`  in  32  host write address; only [ADDR_BITS-1:0] used.
- `wdata`  in  32  host write data.
- `raddr`  in  32  host read address; bit 31 selects status window.
- `flags`  in  32  flags register; [31] command strobe level, [30:28] opcode, [15:0] fill pattern.
- `rdata`  out  32  registered read data, feeds the VDR capture input.
- `busy`  out  1  high while a fill command runs.
- `done`  out  1  one-cycle pulse when a fill completes.

## Operation
- Memory: 2^ADDR_BITS × 32, one write port, one registered read port. Host addresses wrap modulo depth (upper bits ignored).
- Read path:
  - `raddr[31]`=0: `rdata` <= mem[raddr[ADDR_BITS-1:0]].
  - `raddr[31]`=1: `rdata` <= status[raddr[1:0]]:
    - 0: `wr_count`
    - 1: `checksum`
    - 2: `high_water`
    - 3: {`busy`, opcode of last accepted command[2:0], 12'b0, `fill_addr` zero-extended to 16}
- Read-during-write to the same address returns the old data.
- Stats (host writes only; fill writes excluded):
  - `wr_count` += 1 and `checksum` += `wdata`, both mod 2^32.
  - `high_water` = max(`high_water`, waddr[ADDR_BITS-1:0]+1), width ADDR_BITS+1.
- Command detect: `flags_q` registers `flags`[31]. A command is accepted on the 0→1 edge of `flags`[31] only in IDLE. Edges in FILL are ignored and discarded, not queued. Opcodes:
  - 0 CLEAR: fill with 0.
  - 1 FILL: fill with {pattern,pattern}.
  - 2 STATS: zero `wr_count`/`checksum`/`high_water` next cycle; stays IDLE, no `done`.
  - 3..7: no operation, opcode still recorded.
- FSM states:
  - IDLE: on CLEAR/FILL, `fill_addr` <= 0, capture fill word, go to FILL.
  - FILL: each cycle without a host write, write fill word at `fill_addr` and increment. Writing address 2^ADDR_BITS−1 → `done` pulse, back to IDLE.
- Collision: host write has priority. A fill stalls in any cycle where `wram_enable`=1; `fill_addr` is held and the host data is written. Host writes during FILL still update stats and may be overwritten later by the fill.

## Timing
- Reset values: `rdata`=0, `busy`=0, `done`=0, `wr_count`=0, `checksum`=0, `high_water`=0, `fill_addr`=0, recorded opcode=0, `flags_q`=1 (blocks a spurious command if `flags`[31] is already high out of reset). FSM = IDLE. Memory contents are not reset.
- Read latency: 1 cycle from `raddr` to `rdata`. Status reads also take 1 cycle and reflect register values before the current edge's updates.
- Write: memory updated on the edge where `wram_enable`=1. A read issued the following cycle sees the new data.
- Command latency:
  - Edge seen at cycle N → `busy`=1 at N+1, first fill write at N+1.
  - With no stalls, last write at N+2^ADDR_BITS, and in that same cycle `done`=1 and `busy` falls.
  - Each stall cycle delays completion by one.
- `rst` mid-fill: FSM to IDLE, `busy`=0, no `done`; partially filled memory is left as is.
- `rst` and a command edge in the same cycle: `rst` wins and the command is lost.
- STATS and a host write in the same cycle: clear wins and that write is not counted.

## Test plan
- Reset, write 0xA5A5_0001 to addr 5 and 0x0000_0010 to addr 0x405 (ADDR_BITS=10) → read addr 5 = 0x0000_0010. Status0=2, status1=0xA5A5_0011, status2=6.
- Read addr 7 with a same-cycle write of 0x1234 to addr 7 → `rdata`=old value. The next read returns 0x1234.
- `flags`=0x9000_BEEF (FILL), no host traffic → `busy` for 1024 cycles, single `done` pulse, every word = 0xBEEF_BEEF, stats unchanged.
- During FILL, 3 host writes to addr 1023 of 0x55 → completion delayed 3 cycles, addr 1023 = 0xBEEF_BEEF, status0 incremented by 3. A second `flags`[31] edge during FILL is ignored.
- Assert `rst` at fill word 100 → `busy`=0, no `done`, words 0..99 filled. STATS command (0xA000_0000) then zeroes status0..2.
- `flags`[31] held high through reset release → no command accepted until it drops and rises again.

Source files
------------

// File: rtl/jtag_txrx_mem.sv
// Buffer memory behind the JTAG virtual data register: host write/read port,
// fill/clear commands through the flags register, and write statistics in a status window.
module jtag_txrx_mem #(
  parameter int unsigned DR_LENGTH = 32,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 tck,
  input  logic                 rst,
  input  logic                 wram_enable,
  input  logic [DR_LENGTH-1:0] waddr,
  input  logic [DR_LENGTH-1:0] wdata,
  input  logic [DR_LENGTH-1:0] raddr,
  input  logic [DR_LENGTH-1:0] flags,
  output logic [DR_LENGTH-1:0] rdata,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state, state_nxt;
  logic [DR_LENGTH-1:0]   mem [DEPTH];
  logic [ADDR_BITS-1:0]   fill_addr, fill_addr_nxt;
  logic [DR_LENGTH-1:0]   fill_word, fill_word_nxt;
  logic [2:0]             opcode, opcode_nxt;
  logic                   flags_q;
  logic [DR_LENGTH-1:0]   wr_count, checksum;
  logic [ADDR_BITS:0]     high_water;
  logic                   cmd_edge, stats_clr, fill_we, done_nxt;
  logic [ADDR_BITS-1:0]   host_a, rd_a;
  logic [ADDR_BITS:0]     host_top;
  logic [DR_LENGTH-1:0]   status_word;

  assign host_a   = waddr[ADDR_BITS-1:0];
  assign rd_a     = raddr[ADDR_BITS-1:0];
  assign host_top = {1'b0, host_a} + (ADDR_BITS+1)'(1);
  assign cmd_edge = flags[31] & ~flags_q;
  assign busy     = (state == FILL);

  always_comb begin
    state_nxt     = state;
    fill_addr_nxt = fill_addr;
    fill_word_nxt = fill_word;
    opcode_nxt    = opcode;
    stats_clr     = 1'b0;
    fill_we       = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_edge) begin
          opcode_nxt = flags[30:28];
          case (flags[30:28])
            3'd0: begin
              state_nxt     = FILL;
              fill_addr_nxt = '0;
              fill_word_nxt = '0;
            end
            3'd1: begin
              state_nxt     = FILL;
              fill_addr_nxt = '0;
              fill_word_nxt = {flags[15:0], flags[15:0]};
            end
            3'd2:    stats_clr = 1'b1;
            default: ;
          endcase
        end
      end
      FILL: begin
        // Host write owns the single write port; the fill just waits a cycle.
        if (!wram_enable) begin
          fill_we = 1'b1;
          if (fill_addr == '1) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            fill_addr_nxt = fill_addr + ADDR_BITS'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    status_word = '0;
    case (raddr[1:0])
      2'd0: status_word = wr_count;
      2'd1: status_word = checksum;
      2'd2: status_word = DR_LENGTH'(high_water);
      2'd3: status_word = {busy, opcode, 12'b0, 16'(fill_addr)};
      default: ;
    endcase
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      state      <= IDLE;
      fill_addr  <= '0;
      fill_word  <= '0;
      opcode     <= '0;
      flags_q    <= 1'b1;
      done       <= 1'b0;
      wr_count   <= '0;
      checksum   <= '0;
      high_water <= '0;
      rdata      <= '0;
    end else begin
      state     <= state_nxt;
      fill_addr <= fill_addr_nxt;
      fill_word <= fill_word_nxt;
      opcode    <= opcode_nxt;
      flags_q   <= flags[31];
      done      <= done_nxt;
      rdata     <= raddr[31] ? status_word : mem[rd_a];
      if (stats_clr) begin
        wr_count   <= '0;
        checksum   <= '0;
        high_water <= '0;
      end else if (wram_enable) begin
        wr_count <= wr_count + DR_LENGTH'(1);
        checksum <= checksum + wdata;
        if (host_top > high_water) high_water <= host_top;
      end
    end
  end

  // Reset aborts a running fill before it can write the current word.
  always_ff @(posedge tck) begin
    if (wram_enable)          mem[host_a]    <= wdata;
    else if (fill_we && !rst) mem[fill_addr] <= fill_word;
  end

endmodule

// File: tb/tb_jtag_txrx_mem.sv
// Scoreboard bench for jtag_txrx_mem: reads push expected words, a monitor pops
// and compares them when the registered read data appears.
module tb_jtag_txrx_mem;
  localparam int unsigned AB = 10;

  logic        tck = 1'b0;
  logic        rst, wram_enable;
  logic [31:0] waddr, wdata, raddr, flags, rdata;
  logic        busy, done;

  always #5 tck = ~tck;

  jtag_txrx_mem #(.DR_LENGTH(32), .ADDR_BITS(AB)) dut (
    .tck(tck), .rst(rst), .wram_enable(wram_enable), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .flags(flags), .rdata(rdata),
    .busy(busy), .done(done)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic rd_issue = 1'b0;
  logic rd_vld = 1'b0;

  always @(posedge tck) rd_vld <= rd_issue;

  always @(negedge tck) begin
    exp_t e;
    if (rd_vld) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read got 0x%08h with nothing expected", rdata);
      end else begin
        e = sbq.pop_front();
        if (rdata !== e.exp) begin
          miscompares++;
          $display("FAIL %s got 0x%08h expected 0x%08h", e.name, rdata, e.exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wram_enable = 1'b1; waddr = a; wdata = d;
    tick();
    wram_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    raddr = a; rd_issue = 1'b1;
    sbq.push_back('{name, exp});
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic rd_stats(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                          input string tag);
    rd(32'h8000_0000, s0, {tag, "_status0"});
    rd(32'h8000_0001, s1, {tag, "_status1"});
    rd(32'h8000_0002, s2, {tag, "_status2"});
  endtask

  // Edge is sampled on the tick at c=0; fill word k is written on tick c=k+1.
  task automatic run_fill(input int stall_at, input int nstall, input int edge_lo,
                          input int edge_hi, input int rst_at,
                          output int bcyc, output int dcnt,
                          output logic done_at_end, output logic finished);
    bcyc = 0; dcnt = 0; done_at_end = 1'b0; finished = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      wram_enable = (c >= stall_at) && (c < stall_at + nstall);
      waddr = 32'd1023; wdata = 32'h55;
      if (c == edge_lo) flags[31] = 1'b0;
      if (c == edge_hi) flags[31] = 1'b1;
      if (c == rst_at) rst = 1'b1;
      tick();
      if (c == rst_at) begin
        wram_enable = 1'b0;
        return;
      end
      if (done) dcnt++;
      if (busy) bcyc++;
      else if (bcyc > 0) begin
        done_at_end = done;
        finished = 1'b1;
        break;
      end
    end
    wram_enable = 1'b0;
  endtask

  int   bcyc, dcnt, dseen;
  logic dend, fin;

  initial begin
    rst = 1'b1; wram_enable = 1'b0; waddr = '0; wdata = '0; raddr = '0; flags = '0;
    repeat (3) tick();
    check("reset_rdata", rdata, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;
    rd_stats(32'h0, 32'h0, 32'h0, "reset");
    rd(32'h8000_0003, 32'h0, "reset_status3");

    // Address wrap and statistics
    wr(32'd5, 32'hA5A5_0001);
    wr(32'h405, 32'h0000_0010);
    rd(32'd5, 32'h0000_0010, "wrap_addr5");
    rd_stats(32'd2, 32'hA5A5_0011, 32'd6, "wrap");

    // Read-during-write returns old data
    wr(32'd7, 32'h77);
    raddr = 32'd7; rd_issue = 1'b1;
    waddr = 32'd7; wdata = 32'h1234; wram_enable = 1'b1;
    sbq.push_back('{"rdw_old", 32'h77});
    tick();
    rd_issue = 1'b0; wram_enable = 1'b0;
    rd(32'd7, 32'h1234, "rdw_new");
    rd_stats(32'd4, 32'hA5A5_12BC, 32'd8, "rdw");

    // Clean fill
    flags = 32'h9000_BEEF;
    run_fill(-1, 0, -1, -1, -1, bcyc, dcnt, dend, fin);
    check("fill_finished", 32'(fin), 32'h1);
    check("fill_busy_cycles", 32'(bcyc), 32'd1024);
    check("fill_done_count", 32'(dcnt), 32'd1);
    check("fill_done_at_busy_fall", 32'(dend), 32'h1);
    tick();
    check("fill_done_single", 32'(done), 32'h0);
    flags = '0;
    for (int unsigned a = 0; a < 1024; a++) rd(32'(a), 32'hBEEF_BEEF, "fill_word");
    rd_stats(32'd4, 32'hA5A5_12BC, 32'd8, "fill");

    // Fill with three stalling host writes and an ignored second edge
    flags = 32'h9000_BEEF;
    run_fill(10, 3, 20, 22, -1, bcyc, dcnt, dend, fin);
    check("stall_finished", 32'(fin), 32'h1);
    check("stall_busy_cycles", 32'(bcyc), 32'd1027);
    check("stall_done_count", 32'(dcnt), 32'd1);
    check("stall_done_at_busy_fall", 32'(dend), 32'h1);
    repeat (3) tick();
    check("stall_edge_ignored", 32'(busy), 32'h0);
    rd(32'd1023, 32'hBEEF_BEEF, "stall_overwritten");
    rd_stats(32'd7, 32'hA5A5_13BB, 32'd1024, "stall");
    flags = '0;
    tick();

    // Reset at fill word 100, flags left high through reset release
    flags = 32'h9000_1234;
    run_fill(-1, 0, -1, -1, 101, bcyc, dcnt, dend, fin);
    check("rst_fill_busy", 32'(busy), 32'h0);
    check("rst_fill_done", 32'(done), 32'h0);
    rst = 1'b0;
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy || done) dseen++;
    end
    check("held_flag_no_cmd", 32'(dseen), 32'h0);
    rd(32'd0, 32'h1234_1234, "rst_fill_w0");
    rd(32'd50, 32'h1234_1234, "rst_fill_w50");
    rd(32'd99, 32'h1234_1234, "rst_fill_w99");
    rd(32'd100, 32'hBEEF_BEEF, "rst_fill_w100");
    rd_stats(32'h0, 32'h0, 32'h0, "rst_fill");
    rd(32'h8000_0003, 32'h0, "rst_fill_status3");

    // STATS command with a simultaneous host write
    wr(32'd3, 32'hA);
    rd_stats(32'd1, 32'hA, 32'd4, "pre_stats");
    flags = '0;
    tick();
    flags = 32'hA000_0000;
    wr(32'd3, 32'hB);
    rd_stats(32'h0, 32'h0, 32'h0, "stats_clr");
    rd(32'h8000_0003, 32'h2000_0000, "stats_status3");
    rd(32'd3, 32'hB, "stats_mem_write");
    check("stats_not_busy", 32'(busy), 32'h0);

    repeat (2) tick();
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
